// File: rtl/commit_controller_pkg.sv
// Shared types and tag arithmetic for the in-order commit controller.
package commit_controller_pkg;

    // Retirement sequencer states.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ST_WAIT = 2'd1,
        FLUSH   = 2'd2
    } commit_state_t;

    // Modulo ROB tag addition. The ROB depth need not be a power of two, so the
    // wrap is done by compare-and-subtract. Requires tag < size and n <= size.
    function automatic int unsigned rob_tag_add(input int unsigned tag,
                                                input int unsigned n,
                                                input int unsigned size);
        int unsigned sum;
        sum = tag + n;
        if (sum >= size) begin
            sum = sum - size;
        end
        return sum;
    endfunction

endpackage

// File: rtl/commit_controller_if.sv
// ROB / LSQ / flush signal bundle for the commit controller.
// Optional macro COMMIT_CTRL_PERF_EN adds the performance counter outputs.
interface commit_controller_if #(
    parameter int unsigned SIZE         = 15,
    parameter int unsigned COMMIT_WIDTH = 4
);
    localparam int unsigned TAG_W = $clog2(SIZE);
    localparam int unsigned CNT_W = $clog2(COMMIT_WIDTH + 1);

    logic [TAG_W:0]           rob_count;
    logic [SIZE-1:0]          rob_rdy;
    logic [SIZE-1:0]          rob_is_store;
    logic [SIZE-1:0]          rob_mispred;
    logic [SIZE-1:0][31:0]    rob_target;
    logic                     st_commit_ack;
    logic                     commit;
    logic [CNT_W-1:0]         num_deq;
    logic [TAG_W-1:0]         front_tag;
    logic                     st_commit_req;
    logic                     flush_valid;
    logic [31:0]              flush_pc;
`ifdef COMMIT_CTRL_PERF_EN
    logic [31:0]              perf_retired;
    logic [31:0]              perf_flushes;
    logic [31:0]              perf_st_stall;
`endif

    // ROB/LSQ side.
    modport master (
        output rob_count, rob_rdy, rob_is_store, rob_mispred, rob_target, st_commit_ack,
`ifdef COMMIT_CTRL_PERF_EN
        input  perf_retired, perf_flushes, perf_st_stall,
`endif
        input  commit, num_deq, front_tag, st_commit_req, flush_valid, flush_pc
    );

    // Commit controller side.
    modport slave (
        input  rob_count, rob_rdy, rob_is_store, rob_mispred, rob_target, st_commit_ack,
`ifdef COMMIT_CTRL_PERF_EN
        output perf_retired, perf_flushes, perf_st_stall,
`endif
        output commit, num_deq, front_tag, st_commit_req, flush_valid, flush_pc
    );

endinterface

// File: rtl/commit_controller_window_scan.sv
// Combinational priority scan of the retirement window starting at the ROB head.
module commit_window_scan
    import commit_controller_pkg::*;
#(
    parameter int unsigned SIZE         = 15,
    parameter int unsigned COMMIT_WIDTH = 4,
    localparam int unsigned TAG_W = $clog2(SIZE),
    localparam int unsigned CNT_W = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic [TAG_W-1:0] front_tag,
    input  logic [TAG_W:0]   rob_count,
    input  logic [SIZE-1:0]  rob_rdy,
    input  logic [SIZE-1:0]  rob_is_store,
    input  logic [SIZE-1:0]  rob_mispred,
    output logic [CNT_W-1:0] n,
    output logic             store_at_head,
    output logic             mispred_hit,
    output logic [CNT_W-1:0] mispred_k
);

    // Count leading retirable entries; a store or a mispredict closes the group.
    always_comb begin
        logic             stop;
        logic [TAG_W-1:0] slot;
        n             = '0;
        store_at_head = 1'b0;
        mispred_hit   = 1'b0;
        mispred_k     = '0;
        stop          = 1'b0;
        slot          = '0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            if (!stop) begin
                slot = TAG_W'(rob_tag_add(32'(front_tag), k, SIZE));
                if (k < 32'(rob_count) && rob_rdy[slot]) begin
                    if (rob_is_store[slot]) begin
                        // Stores retire alone through the LSQ handshake.
                        store_at_head = (k == 0);
                        stop          = 1'b1;
                    end else begin
                        n = n + CNT_W'(1);
                        if (rob_mispred[slot]) begin
                            mispred_hit = 1'b1;
                            mispred_k   = CNT_W'(k);
                            stop        = 1'b1;
                        end
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/commit_controller.sv
// In-order retirement sequencer: retires ready ROB entries, serialises stores
// through the LSQ, and turns a mispredicted branch into a one-cycle flush.
// Optional macro COMMIT_CTRL_PERF_EN adds saturating performance counters.
module commit_controller
    import commit_controller_pkg::*;
#(
    parameter int unsigned SIZE         = 15,
    parameter int unsigned COMMIT_WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    commit_controller_if.slave bus
);

    localparam int unsigned TAG_W = $clog2(SIZE);
    localparam int unsigned CNT_W = $clog2(COMMIT_WIDTH + 1);

    commit_state_t    state_q, state_d;
    logic [TAG_W-1:0] front_tag_q, front_tag_d;
    logic [31:0]      target_q, target_d;

    logic [CNT_W-1:0] scan_n;
    logic             store_at_head;
    logic             mispred_hit;
    logic [CNT_W-1:0] mispred_k;
    logic [TAG_W-1:0] mispred_slot;

    logic             commit;
    logic [CNT_W-1:0] num_deq;
    logic             st_commit_req;
    logic             flush_valid;
    logic [31:0]      flush_pc;

    commit_window_scan #(
        .SIZE         (SIZE),
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_scan (
        .front_tag     (front_tag_q),
        .rob_count     (bus.rob_count),
        .rob_rdy       (bus.rob_rdy),
        .rob_is_store  (bus.rob_is_store),
        .rob_mispred   (bus.rob_mispred),
        .n             (scan_n),
        .store_at_head (store_at_head),
        .mispred_hit   (mispred_hit),
        .mispred_k     (mispred_k)
    );

    assign mispred_slot = TAG_W'(rob_tag_add(32'(front_tag_q), 32'(mispred_k), SIZE));

    // State, head pointer and redirect target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            front_tag_q <= '0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            front_tag_q <= front_tag_d;
            target_q    <= target_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        front_tag_d   = front_tag_q;
        target_d      = target_q;
        commit        = 1'b0;
        num_deq       = '0;
        st_commit_req = 1'b0;
        flush_valid   = 1'b0;
        flush_pc      = '0;
        unique case (state_q)
            RUN: begin
                if (store_at_head) begin
                    st_commit_req = 1'b1;
                    state_d       = ST_WAIT;
                end else if (scan_n != '0) begin
                    commit      = 1'b1;
                    num_deq     = scan_n;
                    front_tag_d = TAG_W'(rob_tag_add(32'(front_tag_q), 32'(scan_n), SIZE));
                    if (mispred_hit) begin
                        target_d = bus.rob_target[mispred_slot];
                        state_d  = FLUSH;
                    end
                end
            end
            ST_WAIT: begin
                st_commit_req = 1'b1;
                if (bus.st_commit_ack) begin
                    commit      = 1'b1;
                    num_deq     = CNT_W'(1);
                    front_tag_d = TAG_W'(rob_tag_add(32'(front_tag_q), 1, SIZE));
                    state_d     = RUN;
                end
            end
            FLUSH: begin
                flush_valid = 1'b1;
                flush_pc    = target_q;
                front_tag_d = '0;
                state_d     = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.commit        = commit;
    assign bus.num_deq       = num_deq;
    assign bus.front_tag     = front_tag_q;
    assign bus.st_commit_req = st_commit_req;
    assign bus.flush_valid   = flush_valid;
    assign bus.flush_pc      = flush_pc;

`ifdef COMMIT_CTRL_PERF_EN
    logic [31:0] perf_retired_q, perf_flushes_q, perf_st_stall_q;

    // Saturating retirement, flush and store-stall counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_retired_q  <= '0;
            perf_flushes_q  <= '0;
            perf_st_stall_q <= '0;
        end else begin
            if ((32'hFFFF_FFFF - perf_retired_q) >= 32'(num_deq)) begin
                perf_retired_q <= perf_retired_q + 32'(num_deq);
            end else begin
                perf_retired_q <= 32'hFFFF_FFFF;
            end
            if (flush_valid && perf_flushes_q != 32'hFFFF_FFFF) begin
                perf_flushes_q <= perf_flushes_q + 32'd1;
            end
            if (state_q == ST_WAIT && !bus.st_commit_ack && perf_st_stall_q != 32'hFFFF_FFFF) begin
                perf_st_stall_q <= perf_st_stall_q + 32'd1;
            end
        end
    end

    assign bus.perf_retired  = perf_retired_q;
    assign bus.perf_flushes  = perf_flushes_q;
    assign bus.perf_st_stall = perf_st_stall_q;
`endif

endmodule

// File: tb/tb_commit_controller.sv
// Self-checking bench for commit_controller (SIZE=15, COMMIT_WIDTH=4).
module tb_commit_controller;

    logic clk;
    logic rst;

    commit_controller_if #(.SIZE(15), .COMMIT_WIDTH(4)) bus ();

    commit_controller #(
        .SIZE         (15),
        .COMMIT_WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  cnt;
        logic [14:0] rdy;
        logic [14:0] st;
        logic [14:0] mp;
        logic        ack;
        logic        e_commit;
        logic [2:0]  e_ndeq;
        logic [3:0]  e_front;
        logic        chk_req;
        logic        e_req;
        logic        e_flush;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] cnt, input logic [14:0] rdy, input logic [14:0] st,
                         input logic [14:0] mp, input logic ack);
        bus.rob_count     = cnt;
        bus.rob_rdy       = rdy;
        bus.rob_is_store  = st;
        bus.rob_mispred   = mp;
        bus.st_commit_ack = ack;
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            cnt    rdy       st        mp        ack   com  nd    front chk  req  fl   pc
        vecs[0]  = '{5'd0, 15'h7FFF, 15'h0000, 15'h0000, 1'b0, 1'b0, 3'd0, 4'd0,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{5'd6, 15'h003F, 15'h0000, 15'h0000, 1'b0, 1'b1, 3'd4, 4'd0,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{5'd2, 15'h003F, 15'h0000, 15'h0000, 1'b0, 1'b1, 3'd2, 4'd4,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{5'd0, 15'h003F, 15'h0000, 15'h0000, 1'b0, 1'b0, 3'd0, 4'd6,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{5'd3, 15'h0180, 15'h0000, 15'h0000, 1'b0, 1'b0, 3'd0, 4'd6,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{5'd2, 15'h00C0, 15'h0080, 15'h0000, 1'b0, 1'b1, 3'd1, 4'd6,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{5'd2, 15'h00C0, 15'h0080, 15'h0000, 1'b0, 1'b0, 3'd0, 4'd7,  1'b1, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{5'd2, 15'h00C0, 15'h0080, 15'h0000, 1'b0, 1'b0, 3'd0, 4'd7,  1'b1, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{5'd2, 15'h00C0, 15'h0080, 15'h0000, 1'b1, 1'b1, 3'd1, 4'd7,  1'b0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{5'd4, 15'h7FFF, 15'h0000, 15'h0000, 1'b0, 1'b1, 3'd4, 4'd8,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{5'd1, 15'h7FFF, 15'h0000, 15'h0000, 1'b0, 1'b1, 3'd1, 4'd12, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{5'd4, 15'h7FFF, 15'h0000, 15'h0000, 1'b0, 1'b1, 3'd4, 4'd13, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{5'd0, 15'h7FFF, 15'h0000, 15'h0000, 1'b0, 1'b0, 3'd0, 4'd2,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{5'd3, 15'h7FFF, 15'h0000, 15'h0008, 1'b0, 1'b1, 3'd2, 4'd2,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{5'd5, 15'h7FFF, 15'h0000, 15'h0000, 1'b0, 1'b0, 3'd0, 4'd4,  1'b1, 1'b0, 1'b1, 32'h84};
        vecs[15] = '{5'd0, 15'h7FFF, 15'h0000, 15'h0000, 1'b0, 1'b0, 3'd0, 4'd0,  1'b1, 1'b0, 1'b0, 32'h0};

        for (int i = 0; i < 15; i++) begin
            bus.rob_target[i] = 32'h1000 + 32'(i) * 4;
        end
        bus.rob_target[3] = 32'h0000_0084;

        // Reset state.
        rst = 1'b1;
        drive(5'd0, '0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #4;
        check("reset commit", 32'(bus.commit), 32'd0);
        check("reset front_tag", 32'(bus.front_tag), 32'd0);
        check("reset st_commit_req", 32'(bus.st_commit_req), 32'd0);
        check("reset flush_valid", 32'(bus.flush_valid), 32'd0);
        rst = 1'b0;

        // Table-driven vectors, one cycle each, state carried through.
        for (int i = 0; i < 16; i++) begin
            step();
            drive(vecs[i].cnt, vecs[i].rdy, vecs[i].st, vecs[i].mp, vecs[i].ack);
            #3;
            check($sformatf("v%0d commit", i), 32'(bus.commit), 32'(vecs[i].e_commit));
            check($sformatf("v%0d num_deq", i), 32'(bus.num_deq), 32'(vecs[i].e_ndeq));
            check($sformatf("v%0d front_tag", i), 32'(bus.front_tag), 32'(vecs[i].e_front));
            if (vecs[i].chk_req) begin
                check($sformatf("v%0d st_commit_req", i), 32'(bus.st_commit_req),
                      32'(vecs[i].e_req));
            end
            check($sformatf("v%0d flush_valid", i), 32'(bus.flush_valid), 32'(vecs[i].e_flush));
            check($sformatf("v%0d flush_pc", i), bus.flush_pc, vecs[i].e_pc);
        end

        // Store at head, ack three cycles after the request (front_tag = 0).
        step();
        drive(5'd1, 15'h0001, 15'h0001, 15'h0000, 1'b0);
        #3;
        check("st req cycle req", 32'(bus.st_commit_req), 32'd1);
        check("st req cycle num_deq", 32'(bus.num_deq), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            #3;
            check($sformatf("st wait%0d req", i), 32'(bus.st_commit_req), 32'd1);
            check($sformatf("st wait%0d commit", i), 32'(bus.commit), 32'd0);
        end
        step();
        bus.st_commit_ack = 1'b1;
        #3;
        check("st ack commit", 32'(bus.commit), 32'd1);
        check("st ack num_deq", 32'(bus.num_deq), 32'd1);
        check("st ack front_tag", 32'(bus.front_tag), 32'd0);
        step();
        drive(5'd0, '0, '0, '0, 1'b0);
        #3;
        check("st after req", 32'(bus.st_commit_req), 32'd0);
        check("st after front_tag", 32'(bus.front_tag), 32'd1);
        check("st after commit", 32'(bus.commit), 32'd0);

        // Reset pulsed mid-ST_WAIT aborts the store (front_tag = 1).
        step();
        drive(5'd1, 15'h0002, 15'h0002, 15'h0000, 1'b0);
        #3;
        check("rst seq req", 32'(bus.st_commit_req), 32'd1);
        step();
        #3;
        check("rst seq wait req", 32'(bus.st_commit_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rst async req", 32'(bus.st_commit_req), 32'd0);
        check("rst async front_tag", 32'(bus.front_tag), 32'd0);
        check("rst async commit", 32'(bus.commit), 32'd0);
        drive(5'd0, '0, '0, '0, 1'b1);
        step();
        rst = 1'b0;
        step();
        #3;
        check("post rst ack commit", 32'(bus.commit), 32'd0);
        check("post rst ack front_tag", 32'(bus.front_tag), 32'd0);
        check("post rst ack req", 32'(bus.st_commit_req), 32'd0);
        bus.st_commit_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
